// File: rtl/wb_trace_fifo.sv
// Writeback trace FIFO: captures retired-instruction records from the CPU WB stage
// and presents them first-word-fall-through on a valid/ready stream with drop statistics.
module wb_trace_fifo #(
   parameter int DEPTH       = 8,
   parameter bit ONLY_WRITES = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wb_have_inst,
   input  logic [31:0]              wb_pc,
   input  logic                     wb_ena,
   input  logic [4:0]               wb_reg,
   input  logic [31:0]              wb_value,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_pc,
   output logic                     out_ena,
   output logic [4:0]               out_reg,
   output logic [31:0]              out_value,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   input  logic                     clr_ovf,
   output logic [15:0]              drop_cnt,
   output logic [31:0]              retire_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [31:0]   mem_pc_r    [DEPTH];
   logic          mem_ena_r   [DEPTH];
   logic [4:0]    mem_reg_r   [DEPTH];
   logic [31:0]   mem_value_r [DEPTH];

   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          overflow_r;
   logic [15:0]   drop_cnt_r;
   logic [31:0]   retire_cnt_r;

   logic          qual_s;
   logic          full_s;
   logic          pop_s;
   logic          push_s;
   logic          drop_s;

   assign qual_s = wb_have_inst && (!ONLY_WRITES || (wb_ena && (wb_reg != 5'd0)));
   assign full_s = (count_r == DEPTH_C);
   assign pop_s  = out_valid && out_ready;
   assign push_s = qual_s && (!full_s || pop_s);
   assign drop_s = qual_s && full_s && !pop_s;

   // Record storage; fields undefined when ena=0 are stored as zero.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_pc_r[wr_ptr_r]    <= wb_pc;
         mem_ena_r[wr_ptr_r]   <= wb_ena;
         mem_reg_r[wr_ptr_r]   <= wb_ena ? wb_reg : 5'd0;
         mem_value_r[wr_ptr_r] <= wb_ena ? wb_value : 32'd0;
      end
   end

   // Pointers and occupancy; full and empty are told apart by count alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Loss and retire statistics; a drop in the same cycle as clr_ovf wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_r   <= 1'b0;
         drop_cnt_r   <= 16'd0;
         retire_cnt_r <= 32'd0;
      end else begin
         if (drop_s) begin
            overflow_r <= 1'b1;
            if (clr_ovf)                   drop_cnt_r <= 16'd1;
            else if (drop_cnt_r != 16'hFFFF) drop_cnt_r <= drop_cnt_r + 16'd1;
         end else if (clr_ovf) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= 16'd0;
         end
         if (wb_have_inst) retire_cnt_r <= retire_cnt_r + 32'd1;
      end
   end

   // Head record falls through from storage and reads zero while empty.
   always_comb begin
      out_pc    = 32'd0;
      out_ena   = 1'b0;
      out_reg   = 5'd0;
      out_value = 32'd0;
      if (count_r != {CW{1'b0}}) begin
         out_pc    = mem_pc_r[rd_ptr_r];
         out_ena   = mem_ena_r[rd_ptr_r];
         out_reg   = mem_reg_r[rd_ptr_r];
         out_value = mem_value_r[rd_ptr_r];
      end else begin
         out_pc    = 32'd0;
         out_ena   = 1'b0;
         out_reg   = 5'd0;
         out_value = 32'd0;
      end
   end

   assign out_valid  = (count_r != {CW{1'b0}});
   assign count      = count_r;
   assign overflow   = overflow_r;
   assign drop_cnt   = drop_cnt_r;
   assign retire_cnt = retire_cnt_r;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Self-checking bench for wb_trace_fifo: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_wb_trace_fifo;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wb_have_inst = 1'b0;
   logic [31:0] wb_pc = 32'd0;
   logic        wb_ena = 1'b0;
   logic [4:0]  wb_reg = 5'd0;
   logic [31:0] wb_value = 32'd0;
   logic        out_ready = 1'b0;
   logic        clr_ovf = 1'b0;
   logic        out_valid;
   logic [31:0] out_pc;
   logic        out_ena;
   logic [4:0]  out_reg;
   logic [31:0] out_value;
   logic [3:0]  count;
   logic        overflow;
   logic [15:0] drop_cnt;
   logic [31:0] retire_cnt;

   // second instance filters to register writes only
   logic        w_have = 1'b0;
   logic [31:0] w_pc = 32'd0;
   logic        w_ena = 1'b0;
   logic [4:0]  w_reg = 5'd0;
   logic [31:0] w_value = 32'd0;
   logic        w_out_valid;
   logic [31:0] w_out_pc;
   logic        w_out_ena;
   logic [4:0]  w_out_reg;
   logic [31:0] w_out_value;
   logic [3:0]  w_count;
   logic        w_overflow;
   logic [15:0] w_drop_cnt;
   logic [31:0] w_retire_cnt;

   int checks = 0;
   int errors = 0;

   wb_trace_fifo #(.DEPTH(DEPTH), .ONLY_WRITES(1'b0)) u_dut (
      .clk(clk), .reset(reset), .wb_have_inst(wb_have_inst), .wb_pc(wb_pc),
      .wb_ena(wb_ena), .wb_reg(wb_reg), .wb_value(wb_value),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_ena(out_ena), .out_reg(out_reg), .out_value(out_value),
      .count(count), .overflow(overflow), .clr_ovf(clr_ovf),
      .drop_cnt(drop_cnt), .retire_cnt(retire_cnt));

   wb_trace_fifo #(.DEPTH(DEPTH), .ONLY_WRITES(1'b1)) u_dut_w (
      .clk(clk), .reset(reset), .wb_have_inst(w_have), .wb_pc(w_pc),
      .wb_ena(w_ena), .wb_reg(w_reg), .wb_value(w_value),
      .out_valid(w_out_valid), .out_ready(1'b0), .out_pc(w_out_pc),
      .out_ena(w_out_ena), .out_reg(w_out_reg), .out_value(w_out_value),
      .count(w_count), .overflow(w_overflow), .clr_ovf(1'b0),
      .drop_cnt(w_drop_cnt), .retire_cnt(w_retire_cnt));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        ena;
      logic [4:0]  rg;
      logic [31:0] val;
   } rec_t;

   rec_t        mq[$];
   logic        m_ovf = 1'b0;
   logic [15:0] m_drop = 16'd0;
   logic [31:0] m_ret = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: a plain queue of records and the statistics rules
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         m_ovf  = 1'b0;
         m_drop = 16'd0;
         m_ret  = 32'd0;
      end else begin
         bit   pop, full, push, drop;
         rec_t r;
         pop  = (mq.size() != 0) && out_ready;
         full = (mq.size() == DEPTH);
         push = wb_have_inst && (!full || pop);
         drop = wb_have_inst && full && !pop;
         r.pc  = wb_pc;
         r.ena = wb_ena;
         r.rg  = wb_ena ? wb_reg : 5'd0;
         r.val = wb_ena ? wb_value : 32'd0;
         if (pop)  void'(mq.pop_front());
         if (push) mq.push_back(r);
         if (drop) begin
            m_ovf  = 1'b1;
            m_drop = clr_ovf ? 16'd1 : ((m_drop == 16'hFFFF) ? m_drop : m_drop + 16'd1);
         end else if (clr_ovf) begin
            m_ovf  = 1'b0;
            m_drop = 16'd0;
         end
         if (wb_have_inst) m_ret = m_ret + 32'd1;
      end
   end

   // per-cycle comparison of every output against the model
   always @(negedge clk) begin
      rec_t h;
      h.pc = 32'd0; h.ena = 1'b0; h.rg = 5'd0; h.val = 32'd0;
      if (mq.size() != 0) h = mq[0];
      chk("m_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_pc", out_pc, h.pc);
      chk("m_ena", 32'(out_ena), 32'(h.ena));
      chk("m_reg", 32'(out_reg), 32'(h.rg));
      chk("m_value", out_value, h.val);
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_drop_cnt", 32'(drop_cnt), 32'(m_drop));
      chk("m_retire_cnt", retire_cnt, m_ret);
   end

   task automatic drive(input logic h, input logic [31:0] pc, input logic e,
                        input logic [4:0] r, input logic [31:0] v, input logic rdy,
                        input logic clr);
      @(negedge clk);
      wb_have_inst = h; wb_pc = pc; wb_ena = e; wb_reg = r; wb_value = v;
      out_ready = rdy; clr_ovf = clr;
   endtask

   task automatic idle(input logic rdy);
      drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, rdy, 1'b0);
   endtask

   logic [31:0] exp_pc [8];

   initial begin
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_pc", out_pc, 32'd0);
      chk("rst_retire", retire_cnt, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // single push
      drive(1'b1, 32'h4, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b0);
      idle(1'b0);
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_pc", out_pc, 32'h4);
      chk("single_reg", 32'(out_reg), 32'd5);
      chk("single_value", out_value, 32'h1234);
      chk("single_count", 32'(count), 32'd1);
      chk("single_retire", retire_cnt, 32'd1);
      idle(1'b1);
      idle(1'b0);
      chk("single_drained", 32'(count), 32'd0);

      // fill past full: two records dropped
      for (int i = 0; i < 10; i++)
         drive(1'b1, 32'(4 * i), 1'b1, 5'(i + 1), 32'(i), 1'b0, 1'b0);
      idle(1'b0);
      chk("fill_count", 32'(count), 32'd8);
      chk("fill_overflow", 32'(overflow), 32'd1);
      chk("fill_drop", 32'(drop_cnt), 32'd2);
      for (int i = 0; i < 8; i++) begin
         idle(1'b1);
         chk("drain_pc", out_pc, 32'(4 * i));
      end
      idle(1'b0);
      chk("drain_empty", 32'(out_valid), 32'd0);

      // full with simultaneous push and pop
      for (int i = 0; i < 8; i++)
         drive(1'b1, 32'h200 + 32'(4 * i), 1'b1, 5'd1, 32'd0, 1'b0, 1'b0);
      drive(1'b1, 32'h100, 1'b1, 5'd2, 32'd0, 1'b1, 1'b0);
      idle(1'b0);
      chk("pp_count", 32'(count), 32'd8);
      chk("pp_drop", 32'(drop_cnt), 32'd2);
      for (int i = 0; i < 7; i++) exp_pc[i] = 32'h204 + 32'(4 * i);
      exp_pc[7] = 32'h100;
      for (int i = 0; i < 8; i++) begin
         idle(1'b1);
         chk("pp_order", out_pc, exp_pc[i]);
      end
      idle(1'b0);

      // ena=0 masks reg and value
      drive(1'b1, 32'h40, 1'b0, 5'd9, 32'hDEAD, 1'b0, 1'b0);
      idle(1'b0);
      chk("mask_pc", out_pc, 32'h40);
      chk("mask_ena", 32'(out_ena), 32'd0);
      chk("mask_reg", 32'(out_reg), 32'd0);
      chk("mask_value", out_value, 32'd0);
      idle(1'b1);

      // clear racing a drop, then a plain clear
      for (int i = 0; i < 8; i++)
         drive(1'b1, 32'h300 + 32'(4 * i), 1'b1, 5'd3, 32'(i), 1'b0, 1'b0);
      drive(1'b1, 32'h400, 1'b1, 5'd3, 32'd0, 1'b0, 1'b1);
      idle(1'b0);
      chk("race_overflow", 32'(overflow), 32'd1);
      chk("race_drop", 32'(drop_cnt), 32'd1);
      drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      idle(1'b0);
      chk("clr_overflow", 32'(overflow), 32'd0);
      chk("clr_drop", 32'(drop_cnt), 32'd0);
      for (int i = 0; i < 5; i++) idle(1'b1);
      idle(1'b0);
      chk("pre_rst_count", 32'(count), 32'd3);
      chk("pre_rst_head", out_pc, 32'h314);

      // asynchronous reset mid-cycle
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_pc", out_pc, 32'd0);
      chk("arst_retire", retire_cnt, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // write-only filtering on the second instance
      @(negedge clk);
      w_have = 1'b1; w_pc = 32'h10; w_ena = 1'b0; w_reg = 5'd4; w_value = 32'd1;
      @(negedge clk);
      w_pc = 32'h14; w_ena = 1'b1; w_reg = 5'd0; w_value = 32'd2;
      @(negedge clk);
      w_pc = 32'h18; w_ena = 1'b1; w_reg = 5'd3; w_value = 32'd7;
      @(negedge clk);
      w_have = 1'b0;
      @(negedge clk);
      chk("ow_count", 32'(w_count), 32'd1);
      chk("ow_valid", 32'(w_out_valid), 32'd1);
      chk("ow_pc", w_out_pc, 32'h18);
      chk("ow_reg", 32'(w_out_reg), 32'd3);
      chk("ow_value", w_out_value, 32'd7);
      chk("ow_retire", w_retire_cnt, 32'd3);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
